rx_frame_controller: RTL and testbench

RX_FRAME_CONTROLLER -- requirements
Module: rx_frame_controller

---
 rtl/rx_frame_controller.sv | 204 ++++++++++++++++++++
 tb/tb_rx_frame_controller.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_controller.sv
// Rx frame buffer and handshake controller for a 13.56 MHz contactless receiver.
// Optional CRC_A residue check is enabled by defining RX_FRAME_CRC_CHECK_EN.
module rx_frame_controller #(
  parameter int MAX_BYTES = 16,
  parameter int AW        = $clog2(MAX_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          soc,
  input  logic          eoc,
  input  logic [7:0]    data,
  input  logic [2:0]    data_bits,
  input  logic          data_valid,
  input  logic          sequence_error,
  input  logic          parity_error,
  output logic          frame_valid,
  input  logic          frame_ready,
  output logic [AW:0]   frame_len,
  output logic [2:0]    frame_last_bits,
  output logic          frame_short,
  output logic          frame_error,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          frame_dropped
`ifdef RX_FRAME_CRC_CHECK_EN
  ,
  output logic          crc_ok
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  localparam logic [AW:0] MAX_CNT  = MAX_BYTES[AW:0];
  localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          partial_q, partial_d;
  logic [2:0]    last_bits_q, last_bits_d;
  logic          short_q, short_d;
  logic          valid_q, valid_d;
  logic          drop_q, drop_d;
  logic          wr_en_s;
  logic [AW-1:0] wr_addr_s;
  logic          start_s;
  logic          clear_s;
  logic [7:0]    mem_q [MAX_BYTES];

`ifdef RX_FRAME_CRC_CHECK_EN
  logic [15:0]   crc_q, crc_d;
  logic          crc_ok_q, crc_ok_d;

  // CRC_A byte update: reflected 0x8408, data consumed LSB first.
  function automatic logic [15:0] crc_a_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction
`endif

  // Next-state, datapath and flag computation.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    err_d       = err_q;
    partial_d   = partial_q;
    last_bits_d = last_bits_q;
    short_d     = short_q;
    drop_d      = 1'b0;
    wr_en_s     = 1'b0;
    wr_addr_s   = count_q[AW-1:0];
    start_s     = 1'b0;
    clear_s     = 1'b0;
`ifdef RX_FRAME_CRC_CHECK_EN
    crc_d       = crc_q;
    crc_ok_d    = crc_ok_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (soc) begin
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECEIVE: begin
        if (soc) begin
          start_s = 1'b1;
        end else begin
          err_d = err_q | parity_error | sequence_error | (data_valid & partial_q);
          // A byte arriving with eoc is stored before the frame closes.
          if (data_valid && (count_q == MAX_CNT)) begin
            err_d = 1'b1;
          end else if (data_valid) begin
            wr_en_s     = 1'b1;
            count_d     = count_q + CNT_ONE;
            last_bits_d = data_bits;
            partial_d   = (data_bits != 3'd0);
`ifdef RX_FRAME_CRC_CHECK_EN
            crc_d       = (data_bits == 3'd0) ? crc_a_byte(crc_q, data) : crc_q;
`endif
          end else begin
            count_d = count_q;
          end
          if (eoc) begin
            state_d  = ST_HOLD;
            err_d    = err_d | (count_d == CNT_ZERO);
            short_d  = (count_d == CNT_ONE) && (last_bits_d == 3'd7);
`ifdef RX_FRAME_CRC_CHECK_EN
            crc_ok_d = (crc_d == 16'h0000) && (32'(count_d) >= 32'd3);
`endif
          end else begin
            state_d = ST_RECEIVE;
          end
        end
      end
      ST_HOLD: begin
        if (soc) begin
          start_s = 1'b1;
          drop_d  = ~frame_ready;
        end else if (frame_ready) begin
          clear_s = 1'b1;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        clear_s = 1'b1;
      end
    endcase

    // Starting or leaving a frame wipes all per-frame state.
    state_d     = start_s ? ST_RECEIVE : (clear_s ? ST_IDLE : state_d);
    count_d     = (start_s || clear_s) ? CNT_ZERO : count_d;
    err_d       = (start_s || clear_s) ? 1'b0 : err_d;
    partial_d   = (start_s || clear_s) ? 1'b0 : partial_d;
    last_bits_d = (start_s || clear_s) ? 3'd0 : last_bits_d;
    short_d     = (start_s || clear_s) ? 1'b0 : short_d;
`ifdef RX_FRAME_CRC_CHECK_EN
    crc_d       = (start_s || clear_s) ? 16'h6363 : crc_d;
    crc_ok_d    = (start_s || clear_s) ? 1'b0 : crc_ok_d;
`endif
    valid_d     = (state_d == ST_HOLD);
  end

  // Control and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= CNT_ZERO;
      err_q       <= 1'b0;
      partial_q   <= 1'b0;
      last_bits_q <= 3'd0;
      short_q     <= 1'b0;
      valid_q     <= 1'b0;
      drop_q      <= 1'b0;
`ifdef RX_FRAME_CRC_CHECK_EN
      crc_q       <= 16'h6363;
      crc_ok_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_q       <= err_d;
      partial_q   <= partial_d;
      last_bits_q <= last_bits_d;
      short_q     <= short_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
`ifdef RX_FRAME_CRC_CHECK_EN
      crc_q       <= crc_d;
      crc_ok_q    <= crc_ok_d;
`endif
    end
  end

  // Frame buffer storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= data;
    end
  end

  assign rd_data         = ({1'b0, rd_addr} < MAX_CNT) ? mem_q[rd_addr] : 8'h00;
  assign frame_valid     = valid_q;
  assign frame_len       = count_q;
  assign frame_last_bits = last_bits_q;
  assign frame_short     = short_q;
  assign frame_error     = err_q;
  assign frame_dropped   = drop_q;
`ifdef RX_FRAME_CRC_CHECK_EN
  assign crc_ok          = crc_ok_q;
`endif

endmodule

// File: tb/tb_rx_frame_controller.sv
// Scoreboard bench for rx_frame_controller: stimulus queues expected frames,
// a negedge monitor checks each presented frame and its buffer contents.
module tb_rx_frame_controller;

  localparam int MAXB = 16;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          soc = 1'b0;
  logic          eoc = 1'b0;
  logic [7:0]    data = 8'h00;
  logic [2:0]    data_bits = 3'd0;
  logic          data_valid = 1'b0;
  logic          seq_err = 1'b0;
  logic          par_err = 1'b0;
  logic          frame_ready = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          frame_valid;
  logic [AW:0]   frame_len;
  logic [2:0]    frame_last_bits;
  logic          frame_short;
  logic          frame_error;
  logic [7:0]    rd_data;
  logic          frame_dropped;
`ifdef RX_FRAME_CRC_CHECK_EN
  logic          crc_ok;
`endif

  rx_frame_controller #(.MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .soc(soc), .eoc(eoc), .data(data),
    .data_bits(data_bits), .data_valid(data_valid),
    .sequence_error(seq_err), .parity_error(par_err),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_len(frame_len), .frame_last_bits(frame_last_bits),
    .frame_short(frame_short), .frame_error(frame_error),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_dropped(frame_dropped)
`ifdef RX_FRAME_CRC_CHECK_EN
    , .crc_ok(crc_ok)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]        len;
    logic [31:0]        lb;
    logic               sh;
    logic               er;
    logic               cv;
    logic               ck;
    logic [31:0]        cyc;
    logic [31:0]        n;
    logic [MAXB*8-1:0]  bytes;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          drops_seen = 0;
  int          drops_exp = 0;
  int          idx = 0;
  logic        in_frame = 1'b0;
  logic [31:0] snap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    cur = '0;
    soc = 1'b1;
    tick();
    soc = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic [2:0] bits, input bit store);
    if (store) begin
      cur.bytes[cur.n*8 +: 8] = b;
      cur.n = cur.n + 1;
    end
    data = b;
    data_bits = bits;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic finish_frame(input int len, input int lb, input bit sh, input bit er,
                              input bit cv, input bit ck);
    cur.len = len;
    cur.lb  = lb;
    cur.sh  = sh;
    cur.er  = er;
    cur.cv  = cv;
    cur.ck  = ck;
    cur.cyc = cyc + 1;
    exp_q.push_back(cur);
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
  endtask

  task automatic accept(input int hold);
    repeat (hold) tick();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("idle_after_accept", {31'd0, frame_valid}, 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, frame_valid}, 32'd0);
    chk({tag, "_len"}, {27'd0, frame_len}, 32'd0);
    chk({tag, "_last_bits"}, {29'd0, frame_last_bits}, 32'd0);
    chk({tag, "_short"}, {31'd0, frame_short}, 32'd0);
    chk({tag, "_error"}, {31'd0, frame_error}, 32'd0);
    chk({tag, "_dropped"}, {31'd0, frame_dropped}, 32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks each newly presented frame, its stability and buffer contents.
  always @(negedge clk) begin
    if (frame_dropped) drops_seen++;
    if (frame_valid) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        idx = 0;
        if (exp_q.size() == 0) begin
          e = '0;
          total++;
          bad++;
          $display("FAIL unexpected_frame: got frame_len=%0d want no frame", frame_len);
        end else begin
          e = exp_q.pop_front();
          chk("frame_len", {27'd0, frame_len}, e.len);
          chk("frame_last_bits", {29'd0, frame_last_bits}, e.lb);
          chk("frame_short", {31'd0, frame_short}, {31'd0, e.sh});
          chk("frame_error", {31'd0, frame_error}, {31'd0, e.er});
          chk("valid_latency", cyc, e.cyc);
`ifdef RX_FRAME_CRC_CHECK_EN
          if (e.cv) chk("crc_ok", {31'd0, crc_ok}, {31'd0, e.ck});
`endif
        end
        snap = {22'd0, frame_len, frame_last_bits, frame_short, frame_error};
      end else begin
        chk("hold_stable", {22'd0, frame_len, frame_last_bits, frame_short, frame_error}, snap);
      end
      if (idx < int'(e.n)) begin
        rd_addr = idx[AW-1:0];
        #1;
        chk("rd_data", {24'd0, rd_data}, {24'd0, e.bytes[idx*8 +: 8]});
        idx++;
      end
    end else begin
      in_frame = 1'b0;
    end
  end

  initial begin
    repeat (2) tick();
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Short REQA frame, held 10 cycles.
    begin_frame();
    send(8'h26, 3'd7, 1'b1);
    finish_frame(1, 7, 1'b1, 1'b0, 1'b1, 1'b0);
    accept(10);

    // Valid CRC frame; parity pulse during HOLD must be ignored.
    begin_frame();
    send(8'h12, 3'd0, 1'b1);
    send(8'h34, 3'd0, 1'b1);
    send(8'h26, 3'd0, 1'b1);
    send(8'hCF, 3'd0, 1'b1);
    finish_frame(4, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    par_err = 1'b1;
    tick();
    par_err = 1'b0;
    accept(9);

    // Corrupted CRC frame.
    begin_frame();
    send(8'h12, 3'd0, 1'b1);
    send(8'h34, 3'd0, 1'b1);
    send(8'h26, 3'd0, 1'b1);
    send(8'hCE, 3'd0, 1'b1);
    finish_frame(4, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    accept(3);

    // Overflow: MAXB+2 bytes, only the first MAXB kept.
    begin_frame();
    for (int i = 0; i < MAXB + 2; i++) send(8'(i * 7 + 3), 3'd0, i < MAXB);
    finish_frame(MAXB, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    accept(20);

    // Parity error mid-frame.
    begin_frame();
    send(8'hA1, 3'd0, 1'b1);
    par_err = 1'b1;
    send(8'hA2, 3'd0, 1'b1);
    par_err = 1'b0;
    send(8'hA3, 3'd0, 1'b1);
    finish_frame(3, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    accept(4);

    // Errors while IDLE are ignored; data_valid with eoc is counted.
    par_err = 1'b1;
    seq_err = 1'b1;
    tick();
    par_err = 1'b0;
    seq_err = 1'b0;
    begin_frame();
    send(8'h55, 3'd0, 1'b1);
    cur.bytes[cur.n*8 +: 8] = 8'h66;
    cur.n = cur.n + 1;
    data = 8'h66;
    data_bits = 3'd0;
    data_valid = 1'b1;
    finish_frame(2, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    data_valid = 1'b0;
    accept(3);

    // Empty frame.
    begin_frame();
    finish_frame(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    accept(2);

    // Data after a partial byte.
    begin_frame();
    send(8'h0F, 3'd4, 1'b1);
    send(8'h33, 3'd0, 1'b1);
    finish_frame(2, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    accept(3);

    // soc during HOLD drops the held frame.
    begin_frame();
    send(8'h11, 3'd0, 1'b1);
    send(8'h22, 3'd0, 1'b1);
    finish_frame(2, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    cur = '0;
    soc = 1'b1;
    drops_exp++;
    tick();
    soc = 1'b0;
    send(8'h77, 3'd0, 1'b1);
    finish_frame(1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    accept(3);

    // soc together with frame_ready counts as accepted.
    begin_frame();
    send(8'h81, 3'd0, 1'b1);
    finish_frame(1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    cur = '0;
    soc = 1'b1;
    frame_ready = 1'b1;
    tick();
    soc = 1'b0;
    frame_ready = 1'b0;
    send(8'h82, 3'd0, 1'b1);
    send(8'h83, 3'd0, 1'b1);
    finish_frame(2, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    accept(3);

    // Reset mid-frame abandons it; a later eoc in IDLE is ignored.
    begin_frame();
    send(8'h91, 3'd0, 1'b0);
    send(8'h92, 3'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    tick();
    rst_n = 1'b1;
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
    repeat (5) tick();
    chk("no_frame_after_reset", {31'd0, frame_valid}, 32'd0);

    repeat (3) tick();
    chk("dropped_pulses", drops_seen, drops_exp);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
